// File: rtl/uk101_save_pkg.sv
// Shared types and constants for the UK101 ASCII save-to-file capture path.
package uk101_save_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PENDING = 2'd2,
        UPLOAD  = 2'd3
    } state_t;

    localparam logic [7:0] EOF_FILL       = 8'h1A;
    localparam logic [7:0] NUL            = 8'h00;
    localparam int         ADDR_W_DEFAULT = 14;

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: simple dual-port RAM, one write port, one registered read port.
// Read data appears the cycle after rd_en and holds until the next rd_en; contents survive reset.
module capture_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset, so upload data reads 0x00 straight after reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rd_data_q <= 8'h00;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ascii_save_capture.sv
// Captures bytes sent by the ACIA (bit 7 stripped, NULs dropped) and serves them to the HPS upload.
// Upload reads return data 2 cycles after ioctl_rd; bytes past the end read as 0x1A.
module ascii_save_capture
    import uk101_save_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  tx_byte,
    input  logic        tx_strobe,
    input  logic        capture_en,
    input  logic        clear,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [15:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        upload_req,
    output logic [15:0] byte_count,
    output logic        overflow
);
    localparam int            CW       = ADDR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          upload_req_q;
    logic          cen_q;
    logic          upl_q;
    logic          rd_vld_q;
    logic          eof_q;
    logic [15:0]   rd_addr_q;

    logic [7:0]    masked;
    logic [7:0]    ram_rdata;
    logic          full;
    logic          strobe_ok;
    logic          wr_en;
    logic          has_data;
    logic          cen_rise;
    logic          cen_fall;
    logic          upl_fall;
    logic          rd_accept;

    assign masked    = tx_byte & 8'h7F;
    assign full      = (count_q == FULL_CNT);
    assign strobe_ok = tx_strobe && (masked != NUL);
    assign wr_en     = (state_q == CAPTURE) && strobe_ok && !full && !clear;
    // A byte arriving with the disarm edge still counts as buffer content.
    assign has_data  = (count_q != '0) || wr_en;
    assign cen_rise  = capture_en && !cen_q;
    assign cen_fall  = !capture_en && cen_q;
    assign upl_fall  = !ioctl_upload && upl_q;
    assign rd_accept = (state_q == UPLOAD) && ioctl_rd;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            upload_req_q <= 1'b0;
            cen_q        <= 1'b0;
            upl_q        <= 1'b0;
        end else begin
            cen_q <= capture_en;
            upl_q <= ioctl_upload;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                    if (cen_rise) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (clear) begin
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        if (cen_fall) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (wr_en) begin
                            count_q <= count_q + 1'b1;
                        end else if (strobe_ok && full) begin
                            overflow_q <= 1'b1;
                        end
                        if (cen_fall) begin
                            state_q      <= has_data ? PENDING : IDLE;
                            upload_req_q <= has_data;
                        end
                    end
                end
                PENDING: begin
                    if (clear) begin
                        count_q      <= '0;
                        overflow_q   <= 1'b0;
                        state_q      <= IDLE;
                        upload_req_q <= 1'b0;
                    end else if (ioctl_upload) begin
                        state_q      <= UPLOAD;
                        upload_req_q <= 1'b0;
                    end else if (cen_rise) begin
                        state_q      <= CAPTURE;
                        upload_req_q <= 1'b0;
                    end
                end
                UPLOAD: begin
                    if (upl_fall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    upload_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: address register, then RAM output register alongside the end-of-data select.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= 16'h0000;
            eof_q     <= 1'b0;
        end else begin
            rd_vld_q <= rd_accept;
            if (rd_accept) begin
                rd_addr_q <= ioctl_addr;
            end
            if (rd_vld_q) begin
                eof_q <= (rd_addr_q >= byte_count);
            end
        end
    end

    capture_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (wr_en),
        .wr_addr (count_q[ADDR_W-1:0]),
        .wr_data (masked),
        .rd_en   (rd_vld_q),
        .rd_addr (rd_addr_q[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );

    assign byte_count = 16'(count_q);
    assign overflow   = overflow_q;
    assign upload_req = upload_req_q;
    assign ioctl_din  = eof_q ? EOF_FILL : ram_rdata;

endmodule

// File: tb/tb_ascii_save_capture.sv
// Directed bench for ascii_save_capture: a per-cycle vector table plus a buffer-overflow sequence.
module tb_ascii_save_capture;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  tx_byte;
    logic        tx_strobe;
    logic        capture_en;
    logic        clear;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [15:0] ioctl_addr;

    logic [7:0]  din_a, din_b;
    logic        req_a, req_b;
    logic [15:0] cnt_a, cnt_b;
    logic        ovf_a, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ascii_save_capture dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .tx_byte      (tx_byte),
        .tx_strobe    (tx_strobe),
        .capture_en   (capture_en),
        .clear        (clear),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (din_a),
        .upload_req   (req_a),
        .byte_count   (cnt_a),
        .overflow     (ovf_a)
    );

    ascii_save_capture #(.ADDR_W(4)) dut4 (
        .clk          (clk),
        .n_reset      (n_reset),
        .tx_byte      (tx_byte),
        .tx_strobe    (tx_strobe),
        .capture_en   (capture_en),
        .clear        (clear),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (din_b),
        .upload_req   (req_b),
        .byte_count   (cnt_b),
        .overflow     (ovf_b)
    );

    typedef struct {
        logic        rst;
        logic        cen;
        logic        stb;
        logic [7:0]  b;
        logic        clr;
        logic        upl;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] e_cnt;
        logic        e_req;
        logic [7:0]  e_din;
    } vec_t;

    vec_t tbl[$];

    task automatic r(input logic rst, input logic cen, input logic stb, input logic [7:0] b,
                     input logic clr, input logic upl, input logic rd, input logic [15:0] addr,
                     input logic [15:0] e_cnt, input logic e_req, input logic [7:0] e_din);
        vec_t v;
        v.rst = rst; v.cen = cen; v.stb = stb; v.b = b; v.clr = clr;
        v.upl = upl; v.rd = rd; v.addr = addr;
        v.e_cnt = e_cnt; v.e_req = e_req; v.e_din = e_din;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic cen, input logic stb, input logic [7:0] b,
                         input logic clr, input logic upl, input logic rd, input logic [15:0] addr);
        n_reset      = !rst;
        capture_en   = cen;
        tx_strobe    = stb;
        tx_byte      = b;
        clear        = clr;
        ioctl_upload = upl;
        ioctl_rd     = rd;
        ioctl_addr   = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // rst cen stb byte clr upl rd addr | cnt req din
        r(0,1,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h00);
        r(0,1,1,8'h50,0,0,0,16'd0, 16'd1,0,8'h00);
        r(0,1,1,8'hD2,0,0,0,16'd0, 16'd2,0,8'h00);
        r(0,1,1,8'h00,0,0,0,16'd0, 16'd2,0,8'h00);
        r(0,1,1,8'h0D,0,0,0,16'd0, 16'd3,0,8'h00);
        r(0,1,1,8'h0A,0,0,0,16'd0, 16'd4,0,8'h00);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd4,1,8'h00);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd4,1,8'h00);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd4,0,8'h00);
        r(0,0,0,8'h00,0,1,1,16'd0, 16'd4,0,8'h00);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd4,0,8'h50);
        r(0,0,0,8'h00,0,1,1,16'd1, 16'd4,0,8'h50);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd4,0,8'h52);
        r(0,0,0,8'h00,0,1,1,16'd2, 16'd4,0,8'h52);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd4,0,8'h0D);
        r(0,0,0,8'h00,0,1,1,16'd3, 16'd4,0,8'h0D);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd4,0,8'h0A);
        r(0,0,0,8'h00,0,1,1,16'd4, 16'd4,0,8'h0A);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd4,0,8'h1A);
        r(0,0,0,8'h00,0,1,1,16'd5, 16'd4,0,8'h1A);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd4,0,8'h1A);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd4,0,8'h1A);
        r(0,0,0,8'h00,0,0,1,16'd0, 16'd4,0,8'h1A);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd4,0,8'h1A);
        // re-arm from PENDING and append
        r(0,1,0,8'h00,0,0,0,16'd0, 16'd4,0,8'h1A);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd4,1,8'h1A);
        r(0,1,0,8'h00,0,0,0,16'd0, 16'd4,0,8'h1A);
        r(0,1,1,8'h42,0,0,0,16'd0, 16'd5,0,8'h1A);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd5,1,8'h1A);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd5,0,8'h1A);
        r(0,0,0,8'h00,0,1,1,16'd4, 16'd5,0,8'h1A);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd5,0,8'h42);
        r(0,0,0,8'h00,0,1,1,16'd5, 16'd5,0,8'h42);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd5,0,8'h1A);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd5,0,8'h1A);
        r(0,0,1,8'h55,0,0,0,16'd0, 16'd5,0,8'h1A);
        // clear in IDLE, then clear beating a strobe in CAPTURE, empty disarm
        r(0,0,0,8'h00,1,0,0,16'd0, 16'd0,0,8'h1A);
        r(0,1,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h1A);
        r(0,1,1,8'h41,1,0,0,16'd0, 16'd0,0,8'h1A);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h1A);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h1A);
        // strobe coincident with disarm edge; clear ignored during upload
        r(0,1,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h1A);
        r(0,0,1,8'h43,0,0,0,16'd0, 16'd1,1,8'h1A);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd1,0,8'h1A);
        r(0,0,0,8'h00,0,1,1,16'd0, 16'd1,0,8'h1A);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd1,0,8'h43);
        r(0,0,0,8'h00,1,1,0,16'd0, 16'd1,0,8'h43);
        r(0,0,0,8'h00,0,1,1,16'd1, 16'd1,0,8'h43);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd1,0,8'h1A);
        // reset mid-upload with ioctl_upload held high
        r(1,0,0,8'h00,0,1,0,16'd0, 16'd0,0,8'h00);
        r(0,0,0,8'h00,0,1,1,16'd0, 16'd0,0,8'h00);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd0,0,8'h00);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd0,0,8'h00);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h00);
        // clear in PENDING returns to IDLE; later upload is ignored
        r(0,1,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h00);
        r(0,1,1,8'h44,0,0,0,16'd0, 16'd1,0,8'h00);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd1,1,8'h00);
        r(0,0,0,8'h00,1,0,0,16'd0, 16'd0,0,8'h00);
        r(0,0,0,8'h00,0,1,0,16'd0, 16'd0,0,8'h00);
        r(0,0,0,8'h00,0,0,0,16'd0, 16'd0,0,8'h00);

        drive(1,0,0,8'h00,0,0,0,16'd0);
        drive(1,0,0,8'h00,0,0,0,16'd0);
        chk("reset_cnt_a", 0, cnt_a, 16'd0);
        chk("reset_req_a", 0, 16'(req_a), 16'd0);
        chk("reset_ovf_a", 0, 16'(ovf_a), 16'd0);
        chk("reset_din_a", 0, 16'(din_a), 16'h00);
        chk("reset_cnt_b", 0, cnt_b, 16'd0);
        chk("reset_din_b", 0, 16'(din_b), 16'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].cen, tbl[i].stb, tbl[i].b, tbl[i].clr,
                  tbl[i].upl, tbl[i].rd, tbl[i].addr);
            chk("cnt_a", i, cnt_a, tbl[i].e_cnt);
            chk("req_a", i, 16'(req_a), 16'(tbl[i].e_req));
            chk("din_a", i, 16'(din_a), 16'(tbl[i].e_din));
            chk("ovf_a", i, 16'(ovf_a), 16'd0);
            chk("cnt_b", i, cnt_b, tbl[i].e_cnt);
            chk("req_b", i, 16'(req_b), 16'(tbl[i].e_req));
            chk("din_b", i, 16'(din_b), 16'(tbl[i].e_din));
        end

        // Overflow: the 16-byte instance saturates, the default one keeps all 18 bytes
        drive(0,1,0,8'h00,0,0,0,16'd0);
        for (int i = 0; i < 18; i++) begin
            drive(0,1,1,8'(8'h61 + i),0,0,0,16'd0);
        end
        chk("ovf_cnt_b", 0, cnt_b, 16'd16);
        chk("ovf_flag_b", 0, 16'(ovf_b), 16'd1);
        chk("ovf_cnt_a", 0, cnt_a, 16'd18);
        chk("ovf_flag_a", 0, 16'(ovf_a), 16'd0);
        drive(0,0,0,8'h00,0,0,0,16'd0);
        chk("ovf_req_b", 0, 16'(req_b), 16'd1);
        drive(0,0,0,8'h00,0,1,0,16'd0);
        drive(0,0,0,8'h00,0,1,1,16'd0);
        drive(0,0,0,8'h00,0,1,0,16'd0);
        chk("ovf_addr0_b", 0, 16'(din_b), 16'h61);
        chk("ovf_addr0_a", 0, 16'(din_a), 16'h61);
        drive(0,0,0,8'h00,0,1,1,16'd15);
        drive(0,0,0,8'h00,0,1,0,16'd0);
        chk("ovf_addr15_b", 0, 16'(din_b), 16'h70);
        drive(0,0,0,8'h00,0,1,1,16'd16);
        drive(0,0,0,8'h00,0,1,0,16'd0);
        chk("ovf_addr16_b", 0, 16'(din_b), 16'h1A);
        chk("ovf_addr16_a", 0, 16'(din_a), 16'h71);
        drive(0,0,0,8'h00,1,1,0,16'd0);
        chk("upl_clear_ovf_b", 0, 16'(ovf_b), 16'd1);
        chk("upl_clear_cnt_b", 0, cnt_b, 16'd16);
        drive(0,0,0,8'h00,0,0,0,16'd0);
        drive(0,0,0,8'h00,1,0,0,16'd0);
        chk("idle_clear_ovf_b", 0, 16'(ovf_b), 16'd0);
        chk("idle_clear_cnt_b", 0, cnt_b, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
